// File: rtl/icu_wide.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | icu_wide : MC14500B-style instruction control unit, DATA_W-bit result    |
// |            register, return-address stack and backpressured store path. |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module icu_wide #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instruction,
    input  logic [ADDR_W-1:0] operand,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] rr_out,
    output logic              jmp,
    output logic              rtn,
    output logic [ADDR_W-1:0] target_addr,
    output logic              flag_o,
    output logic              flag_f,
    output logic [LVL_W-1:0]  stk_level,
    output logic              stk_ovf,
    output logic              stk_unf
);

    localparam logic [3:0] c_op_nopo = 4'h0;
    localparam logic [3:0] c_op_ld   = 4'h1;
    localparam logic [3:0] c_op_ldc  = 4'h2;
    localparam logic [3:0] c_op_and  = 4'h3;
    localparam logic [3:0] c_op_andc = 4'h4;
    localparam logic [3:0] c_op_or   = 4'h5;
    localparam logic [3:0] c_op_orc  = 4'h6;
    localparam logic [3:0] c_op_xnor = 4'h7;
    localparam logic [3:0] c_op_sto  = 4'h8;
    localparam logic [3:0] c_op_stoc = 4'h9;
    localparam logic [3:0] c_op_ien  = 4'hA;
    localparam logic [3:0] c_op_oen  = 4'hB;
    localparam logic [3:0] c_op_jmp  = 4'hC;
    localparam logic [3:0] c_op_rtn  = 4'hD;
    localparam logic [3:0] c_op_skz  = 4'hE;
    localparam logic [3:0] c_op_nopf = 4'hF;

    localparam logic [LVL_W-1:0] c_full = LVL_W'(STACK_DEPTH);

    logic              r_rst_sync;
    logic              r_ien;
    logic              r_oen;
    logic              r_skip;
    logic [DATA_W-1:0] r_rr;
    logic [LVL_W-1:0]  r_level;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_accept;
    logic              w_exec;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_din_m;
    logic [ADDR_W-1:0] w_top;

    assign instr_ready = r_rst_sync && !(wr_valid && !wr_ready);
    assign w_accept    = instr_valid && instr_ready;
    assign w_exec      = w_accept && !r_skip;
    assign w_full      = (r_level == c_full);
    assign w_empty     = (r_level == '0);
    assign w_din_m     = data_in & {DATA_W{r_ien}};
    assign rr_out      = r_rr;
    assign stk_level   = r_level;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_level == LVL_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Pushes on a full stack are dropped so existing entries are never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_exec) begin
            if (instruction == c_op_jmp && !w_full) begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (r_level == LVL_W'(i)) begin
                        r_stack[i] <= instr_addr + ADDR_W'(1);
                    end
                end
                r_level <= r_level + LVL_W'(1);
            end else if (instruction == c_op_rtn && !w_empty) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync  <= 1'b0;
            r_ien       <= 1'b0;
            r_oen       <= 1'b0;
            r_skip      <= 1'b0;
            r_rr        <= '0;
            wr_valid    <= 1'b0;
            data_out    <= '0;
            jmp         <= 1'b0;
            rtn         <= 1'b0;
            flag_o      <= 1'b0;
            flag_f      <= 1'b0;
            target_addr <= '0;
            stk_ovf     <= 1'b0;
            stk_unf     <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
            jmp        <= 1'b0;
            rtn        <= 1'b0;
            flag_o     <= 1'b0;
            flag_f     <= 1'b0;

            // A new store issued on the completing edge overrides the clear below.
            if (wr_valid && wr_ready) begin
                wr_valid <= 1'b0;
                data_out <= '0;
            end

            if (w_accept) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    case (instruction)
                        c_op_nopo: flag_o <= 1'b1;
                        c_op_ld:   r_rr <= w_din_m;
                        c_op_ldc:  r_rr <= ~w_din_m;
                        c_op_and:  r_rr <= r_rr & w_din_m;
                        c_op_andc: r_rr <= r_rr & ~w_din_m;
                        c_op_or:   r_rr <= r_rr | w_din_m;
                        c_op_orc:  r_rr <= r_rr | ~w_din_m;
                        c_op_xnor: r_rr <= ~(r_rr ^ w_din_m);
                        c_op_sto: begin
                            if (r_oen) begin
                                wr_valid <= 1'b1;
                                data_out <= r_rr;
                            end
                        end
                        c_op_stoc: begin
                            if (r_oen) begin
                                wr_valid <= 1'b1;
                                data_out <= ~r_rr;
                            end
                        end
                        c_op_ien:  r_ien <= data_in[0];
                        c_op_oen:  r_oen <= w_din_m[0];
                        c_op_jmp: begin
                            jmp         <= 1'b1;
                            target_addr <= operand;
                            if (w_full) begin
                                stk_ovf <= 1'b1;
                            end
                        end
                        c_op_rtn: begin
                            rtn    <= 1'b1;
                            r_skip <= 1'b1;
                            if (w_empty) begin
                                target_addr <= '0;
                                stk_unf     <= 1'b1;
                            end else begin
                                target_addr <= w_top;
                            end
                        end
                        c_op_skz:  r_skip <= (r_rr == '0);
                        c_op_nopf: flag_f <= 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icu_wide.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_icu_wide : directed self-checking bench for icu_wide.                |
// | Revision    : 1.0                                                       |
// +------------------------------------------------------------------------+
module tb_icu_wide;

    localparam logic [3:0] c_nopo = 4'h0, c_ld = 4'h1, c_ldc = 4'h2, c_xnor = 4'h7;
    localparam logic [3:0] c_sto = 4'h8, c_stoc = 4'h9, c_ien = 4'hA, c_oen = 4'hB;
    localparam logic [3:0] c_jmp = 4'hC, c_rtn = 4'hD, c_skz = 4'hE, c_nopf = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instruction;
    logic [7:0] operand;
    logic [7:0] instr_addr;
    logic [7:0] data_in;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] data_out;
    logic [7:0] rr_out;
    logic       jmp;
    logic       rtn;
    logic [7:0] target_addr;
    logic       flag_o;
    logic       flag_f;
    logic [2:0] stk_level;
    logic       stk_ovf;
    logic       stk_unf;

    int n_checks = 0;
    int n_errors = 0;

    icu_wide #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .STACK_DEPTH (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .operand     (operand),
        .instr_addr  (instr_addr),
        .data_in     (data_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .data_out    (data_out),
        .rr_out      (rr_out),
        .jmp         (jmp),
        .rtn         (rtn),
        .target_addr (target_addr),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .stk_level   (stk_level),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction for one edge; returns 1 ns after that edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] d,
                         input logic [7:0] addr, input logic [7:0] opnd);
        instr_valid = 1'b1;
        instruction = op;
        data_in     = d;
        instr_addr  = addr;
        operand     = opnd;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_ready    = 1'b1;
        instr_valid = 1'b0;
        instruction = 4'h0;
        operand     = 8'h00;
        instr_addr  = 8'h00;
        data_in     = 8'h00;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            instr_valid = 1'($urandom);
            instruction = 4'($urandom);
            data_in     = 8'($urandom);
            operand     = 8'($urandom);
            instr_addr  = 8'($urandom);
            wr_ready    = 1'($urandom);
        end
        check("rst_outputs", {instr_ready, wr_valid, jmp, rtn, flag_o, flag_f, stk_ovf, stk_unf}, 0);
        check("rst_data", {data_out, rr_out, target_addr, 5'b0, stk_level}, 0);

        instr_valid = 1'b0;
        wr_ready    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", instr_ready, 0);
        idle();
        check("ready_after_edge", instr_ready, 1);

        // Logic path
        issue(c_ien, 8'h01, 8'h00, 8'h00);
        issue(c_oen, 8'h01, 8'h00, 8'h00);
        issue(c_ld, 8'hA5, 8'h00, 8'h00);
        check("ld_rr", rr_out, 8'hA5);
        issue(c_xnor, 8'h0F, 8'h00, 8'h00);
        check("xnor_rr", rr_out, 8'h55);
        check("no_write_yet", wr_valid, 0);
        issue(c_sto, 8'h00, 8'h00, 8'h00);
        check("sto_wr_valid", wr_valid, 1);
        check("sto_data", data_out, 8'h55);
        check("sto_rr", rr_out, 8'h55);
        idle();
        check("sto_ack_clear", wr_valid, 0);
        check("data_out_zero", data_out, 0);

        // Backpressure with STOC
        wr_ready = 1'b0;
        issue(c_stoc, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", instr_ready, 0);
            check("bp_data", data_out, 8'hAA);
            check("bp_valid", wr_valid, 1);
            idle();
        end
        wr_ready = 1'b1;
        #1;
        check("bp_ready_release", instr_ready, 1);
        idle();
        check("bp_valid_clear", wr_valid, 0);
        check("bp_ready_after", instr_ready, 1);

        // Skip
        issue(c_ld, 8'h00, 8'h00, 8'h00);
        check("ld_zero", rr_out, 0);
        issue(c_skz, 8'h00, 8'h00, 8'h00);
        issue(c_sto, 8'h00, 8'h00, 8'h00);
        check("skipped_sto", wr_valid, 0);
        issue(c_ldc, 8'h00, 8'h00, 8'h00);
        check("ldc_rr", rr_out, 8'hFF);
        issue(c_skz, 8'h00, 8'h00, 8'h00);
        issue(c_nopo, 8'h00, 8'h00, 8'h00);
        check("nopo_pulse", flag_o, 1);
        idle();
        check("nopo_one_cycle", flag_o, 0);

        // Return stack: 5 JMPs, last one overflows
        for (int i = 0; i < 5; i++) begin
            issue(c_jmp, 8'h00, 8'h10 + 8'(i), 8'h80 + 8'(i));
            check("jmp_pulse", jmp, 1);
            check("jmp_target", target_addr, 8'h80 + 8'(i));
            check("jmp_level", stk_level, (i < 4) ? i + 1 : 4);
            check("jmp_ovf", stk_ovf, (i == 4) ? 1 : 0);
        end
        idle();
        check("jmp_pulse_end", jmp, 0);

        for (int i = 0; i < 4; i++) begin
            issue(c_rtn, 8'h00, 8'h00, 8'h00);
            check("rtn_pulse", rtn, 1);
            check("rtn_target", target_addr, 8'h14 - 8'(i));
            check("rtn_level", stk_level, 3 - i);
            issue(c_nopf, 8'h00, 8'h00, 8'h00);
            check("nopf_skipped", flag_f, 0);
            check("rtn_pulse_end", rtn, 0);
        end
        check("unf_clear", stk_unf, 0);
        issue(c_rtn, 8'h00, 8'h00, 8'h00);
        check("unf_rtn_pulse", rtn, 1);
        check("unf_target", target_addr, 0);
        check("unf_flag", stk_unf, 1);
        check("unf_level", stk_level, 0);
        issue(c_nopf, 8'h00, 8'h00, 8'h00);
        check("unf_nopf_skipped", flag_f, 0);
        issue(c_nopf, 8'h00, 8'h00, 8'h00);
        check("nopf_pulse", flag_f, 1);
        check("ovf_sticky", stk_ovf, 1);

        // Reset during a pending store
        issue(c_ld, 8'h3C, 8'h00, 8'h00);
        wr_ready = 1'b0;
        issue(c_sto, 8'h00, 8'h00, 8'h00);
        check("pend_store", data_out, 8'h3C);
        rst_n = 1'b0;
        #1;
        check("rst_drop_store", wr_valid, 0);
        check("rst_flags", {stk_ovf, stk_unf, instr_ready}, 0);
        check("rst_rr", rr_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
